// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline: ALU command encodings and the
// ID/EX control bundle.
package arm_pkg;

    localparam int unsigned WORD_DEFAULT = 32;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b0100;
    localparam logic [3:0] EXE_TST = 4'b0110;
    localparam logic [3:0] EXE_LDR = 4'b0010;
    localparam logic [3:0] EXE_STR = 4'b0010;

    typedef struct packed {
        logic       mem_r_en;
        logic       mem_w_en;
        logic       wb_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_pipe_reg_field.sv
// Pipeline field group register: reset, then flush, then freeze, then load.
module pipe_field_reg #(
    parameter int unsigned     W        = 8,
    parameter logic [W-1:0]    FlushVal = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         freeze,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] val_d;
    logic [W-1:0] val_q;

    always_comb begin
        val_d = val_q;
        if (flush) begin
            val_d = FlushVal;
        end else if (!freeze) begin
            val_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: control, tags and operands from ID, with stall,
// squash-to-bubble and a saturating bubble counter.
module id_ex_pipe_reg
    import arm_pkg::*;
#(
    parameter int unsigned WORD  = WORD_DEFAULT,
    parameter int unsigned BUB_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WORD-1:0]  id_pc,
    input  logic [WORD-1:0]  id_val_rn,
    input  logic [WORD-1:0]  id_val_rm,
    input  logic [11:0]      id_shift_operand,
    input  logic             id_imm,
    input  logic [23:0]      id_signed_imm_24,
    input  logic [3:0]       id_dst,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic [3:0]       id_exe_cmd,
    input  logic             id_mem_r_en,
    input  logic             id_mem_w_en,
    input  logic             id_wb_en,
    input  logic             id_b,
    input  logic             id_s,
    input  logic             id_carry,
    output logic             ex_valid,
    output logic [WORD-1:0]  ex_pc,
    output logic [WORD-1:0]  ex_val_rn,
    output logic [WORD-1:0]  ex_val_rm,
    output logic [11:0]      ex_shift_operand,
    output logic             ex_imm,
    output logic [23:0]      ex_signed_imm_24,
    output logic [3:0]       ex_dst,
    output logic [3:0]       ex_src1,
    output logic [3:0]       ex_src2,
    output logic [3:0]       ex_exe_cmd,
    output logic             ex_mem_r_en,
    output logic             ex_mem_w_en,
    output logic             ex_wb_en,
    output logic             ex_b,
    output logic             ex_s,
    output logic             ex_carry,
    output logic [BUB_W-1:0] bubble_cnt
);

    localparam int unsigned CtrlW = $bits(id_ex_ctrl_t) + 1;
    localparam int unsigned TagW  = 12;
    localparam int unsigned DataW = 3 * WORD + 12 + 1 + 24 + 1;

    id_ex_ctrl_t       ctrl_in;
    id_ex_ctrl_t       ctrl_out;
    logic [CtrlW-1:0]  ctrl_d;
    logic [CtrlW-1:0]  ctrl_q;
    logic [TagW-1:0]   tag_q;
    logic [DataW-1:0]  data_q;
    logic [BUB_W-1:0]  bubble_cnt_d;
    logic [BUB_W-1:0]  bubble_cnt_q;
    logic              bub_inc;

    // Gating control by id_valid keeps ex_valid==0 => no side-effecting control.
    always_comb begin
        ctrl_in = '{mem_r_en: id_mem_r_en, mem_w_en: id_mem_w_en, wb_en: id_wb_en,
                    b: id_b, s: id_s, exe_cmd: id_exe_cmd};
        ctrl_d  = id_valid ? {1'b1, ctrl_in} : '0;
    end

    pipe_field_reg #(.W(CtrlW)) u_ctrl_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .freeze (freeze),
        .d      (ctrl_d),
        .q      (ctrl_q)
    );

    pipe_field_reg #(.W(TagW)) u_tag_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .freeze (freeze),
        .d      ({id_dst, id_src1, id_src2}),
        .q      (tag_q)
    );

    pipe_field_reg #(.W(DataW)) u_data_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .freeze (freeze),
        .d      ({id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm,
                  id_signed_imm_24, id_carry}),
        .q      (data_q)
    );

    always_comb begin
        bub_inc      = flush || (!freeze && !id_valid);
        bubble_cnt_d = bubble_cnt_q;
        if (bub_inc && (bubble_cnt_q != {BUB_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + BUB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ctrl_out    = ctrl_q[CtrlW-2:0];
    assign ex_valid    = ctrl_q[CtrlW-1];
    assign ex_mem_r_en = ctrl_out.mem_r_en;
    assign ex_mem_w_en = ctrl_out.mem_w_en;
    assign ex_wb_en    = ctrl_out.wb_en;
    assign ex_b        = ctrl_out.b;
    assign ex_s        = ctrl_out.s;
    assign ex_exe_cmd  = ctrl_out.exe_cmd;

    assign {ex_dst, ex_src1, ex_src2} = tag_q;
    assign {ex_pc, ex_val_rn, ex_val_rm, ex_shift_operand, ex_imm,
            ex_signed_imm_24, ex_carry} = data_q;

    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg, built with a 2-bit bubble counter so
// saturation is reachable quickly.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n, freeze, flush, id_valid;
    logic [31:0] id_pc, id_val_rn, id_val_rm;
    logic [11:0] id_shift_operand;
    logic        id_imm;
    logic [23:0] id_signed_imm_24;
    logic [3:0]  id_dst, id_src1, id_src2, id_exe_cmd;
    logic        id_mem_r_en, id_mem_w_en, id_wb_en, id_b, id_s, id_carry;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
    logic [11:0] ex_shift_operand;
    logic        ex_imm;
    logic [23:0] ex_signed_imm_24;
    logic [3:0]  ex_dst, ex_src1, ex_src2, ex_exe_cmd;
    logic        ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_b, ex_s, ex_carry;
    logic [1:0]  bubble_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.WORD(32), .BUB_W(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .freeze           (freeze),
        .flush            (flush),
        .id_valid         (id_valid),
        .id_pc            (id_pc),
        .id_val_rn        (id_val_rn),
        .id_val_rm        (id_val_rm),
        .id_shift_operand (id_shift_operand),
        .id_imm           (id_imm),
        .id_signed_imm_24 (id_signed_imm_24),
        .id_dst           (id_dst),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_exe_cmd       (id_exe_cmd),
        .id_mem_r_en      (id_mem_r_en),
        .id_mem_w_en      (id_mem_w_en),
        .id_wb_en         (id_wb_en),
        .id_b             (id_b),
        .id_s             (id_s),
        .id_carry         (id_carry),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_val_rn        (ex_val_rn),
        .ex_val_rm        (ex_val_rm),
        .ex_shift_operand (ex_shift_operand),
        .ex_imm           (ex_imm),
        .ex_signed_imm_24 (ex_signed_imm_24),
        .ex_dst           (ex_dst),
        .ex_src1          (ex_src1),
        .ex_src2          (ex_src2),
        .ex_exe_cmd       (ex_exe_cmd),
        .ex_mem_r_en      (ex_mem_r_en),
        .ex_mem_w_en      (ex_mem_w_en),
        .ex_wb_en         (ex_wb_en),
        .ex_b             (ex_b),
        .ex_s             (ex_s),
        .ex_carry         (ex_carry),
        .bubble_cnt       (bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every id_* field nonzero
        rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; id_valid = 1'b1;
        id_pc = 32'hDEAD_BEEF; id_val_rn = 32'h1111_1111; id_val_rm = 32'h2222_2222;
        id_shift_operand = 12'hABC; id_imm = 1'b1; id_signed_imm_24 = 24'h123456;
        id_dst = 4'hF; id_src1 = 4'hE; id_src2 = 4'hD; id_exe_cmd = arm_pkg::EXE_SUB;
        id_mem_r_en = 1'b1; id_mem_w_en = 1'b1; id_wb_en = 1'b1; id_b = 1'b1; id_s = 1'b1;
        id_carry = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_valid", 32'(ex_valid), 0);
            chk("rst_pc", ex_pc, 0);
            chk("rst_wb_en", 32'(ex_wb_en), 0);
            chk("rst_dst", 32'(ex_dst), 0);
            chk("rst_imm24", 32'(ex_signed_imm_24), 0);
            chk("rst_bubble", 32'(bubble_cnt), 0);
        end
        rst_n = 1'b1;
        tick();
        chk("rel_pc", ex_pc, 32'hDEAD_BEEF);
        chk("rel_valid", 32'(ex_valid), 1);
        chk("rel_ctrl", 32'({ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_b, ex_s}), 32'h1F);
        chk("rel_cmd", 32'(ex_exe_cmd), 32'(arm_pkg::EXE_SUB));
        chk("rel_shift", 32'(ex_shift_operand), 32'hABC);
        chk("rel_imm24", 32'(ex_signed_imm_24), 32'h123456);
        chk("rel_carry", 32'(ex_carry), 1);
        chk("rel_bubble", 32'(bubble_cnt), 0);

        // Normal flow: instruction A
        id_pc = 32'h104; id_dst = 4'd3; id_src1 = 4'd1; id_src2 = 4'd2; id_wb_en = 1'b1;
        id_exe_cmd = arm_pkg::EXE_ADD; id_mem_r_en = 1'b0; id_mem_w_en = 1'b0;
        id_b = 1'b0; id_s = 1'b0; id_carry = 1'b0;
        tick();
        chk("nrm_pc", ex_pc, 32'h104);
        chk("nrm_tags", 32'({ex_dst, ex_src1, ex_src2}), 32'h312);
        chk("nrm_cmd", 32'(ex_exe_cmd), 32'h2);
        chk("nrm_wb", 32'(ex_wb_en), 1);
        chk("nrm_mem", 32'({ex_mem_r_en, ex_mem_w_en, ex_b, ex_s}), 0);
        chk("nrm_valid", 32'(ex_valid), 1);

        // Freeze for 3 cycles with B waiting on id_*
        id_pc = 32'h200; id_dst = 4'd7; id_exe_cmd = arm_pkg::EXE_ORR; freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_pc", ex_pc, 32'h104);
            chk("frz_dst", 32'(ex_dst), 3);
            chk("frz_cmd", 32'(ex_exe_cmd), 32'h2);
            chk("frz_bubble", 32'(bubble_cnt), 0);
        end
        freeze = 1'b0;
        tick();
        chk("unfrz_pc", ex_pc, 32'h200);
        chk("unfrz_dst", 32'(ex_dst), 7);
        chk("unfrz_cmd", 32'(ex_exe_cmd), 32'h7);

        // Flush beats freeze
        id_dst = 4'd5; id_wb_en = 1'b1; freeze = 1'b1; flush = 1'b1;
        tick();
        chk("fl_valid", 32'(ex_valid), 0);
        chk("fl_wb", 32'(ex_wb_en), 0);
        chk("fl_dst", 32'(ex_dst), 0);
        chk("fl_pc", ex_pc, 0);
        chk("fl_cmd", 32'(ex_exe_cmd), 0);
        chk("fl_bubble", 32'(bubble_cnt), 1);

        // Invalid slot: control forced low, data still loads
        freeze = 1'b0; flush = 1'b0; id_valid = 1'b0; id_wb_en = 1'b1; id_mem_w_en = 1'b1;
        id_pc = 32'h300; id_val_rn = 32'h1234; id_dst = 4'd9;
        tick();
        chk("inv_valid", 32'(ex_valid), 0);
        chk("inv_wb", 32'(ex_wb_en), 0);
        chk("inv_memw", 32'(ex_mem_w_en), 0);
        chk("inv_cmd", 32'(ex_exe_cmd), 0);
        chk("inv_pc", ex_pc, 32'h300);
        chk("inv_rn", ex_val_rn, 32'h1234);
        chk("inv_dst", 32'(ex_dst), 9);
        chk("inv_bubble", 32'(bubble_cnt), 2);

        // Frozen invalid slot does not count a bubble
        freeze = 1'b1;
        tick();
        chk("frzinv_bubble", 32'(bubble_cnt), 2);

        // Valid instruction holds the counter
        freeze = 1'b0; id_valid = 1'b1; id_mem_w_en = 1'b0;
        tick();
        chk("val_bubble", 32'(bubble_cnt), 2);
        chk("val_valid", 32'(ex_valid), 1);
        chk("val_wb", 32'(ex_wb_en), 1);

        // Reset during freeze and flush
        rst_n = 1'b0; freeze = 1'b1; flush = 1'b1;
        tick();
        chk("rstff_valid", 32'(ex_valid), 0);
        chk("rstff_pc", ex_pc, 0);
        chk("rstff_bubble", 32'(bubble_cnt), 0);
        rst_n = 1'b1; freeze = 1'b0; flush = 1'b0; id_pc = 32'h400;
        tick();
        chk("postrst_pc", ex_pc, 32'h400);
        chk("postrst_valid", 32'(ex_valid), 1);

        // Saturation with a 2-bit counter
        flush = 1'b1;
        tick(); chk("sat1", 32'(bubble_cnt), 1);
        tick(); chk("sat2", 32'(bubble_cnt), 2);
        tick(); chk("sat3", 32'(bubble_cnt), 3);
        tick(); chk("sat4", 32'(bubble_cnt), 3);
        tick(); chk("sat5", 32'(bubble_cnt), 3);
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
